// File: rtl/mileage_recorder_pkg.sv
// mileage_recorder_pkg
//   Shared constants and types for the mileage recorder slice.
//   MILEAGE_W   : width of the mileage record (27 bits covers 0..99_999_999)
//   MILEAGE_MAX : largest value the 8-digit display path can show
//   state_t     : FSM state encoding, also exported on the 'state' port
package mileage_recorder_pkg;

  localparam int unsigned MILEAGE_W = 27;
  localparam logic [MILEAGE_W-1:0] MILEAGE_MAX = MILEAGE_W'(99_999_999);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    IDLE  = 2'd1,
    DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/mileage_recorder_tick_gen.sv
// tick_gen
//   Drive-time prescaler. Counts 0..TICKS_PER_UNIT-1 while en is high and
//   pulses tick for one cycle on the terminal count, wrapping to 0 on the
//   same edge. Dropping en discards any partial count.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     en    : count enable (vehicle in DRIVE and no clear applied)
//     tick  : one-cycle pulse, high while the counter sits at its last value
//   Parameter TICKS_PER_UNIT : clk cycles per mileage unit (2..2^27-1)
module tick_gen #(
  parameter int unsigned TICKS_PER_UNIT = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICKS_PER_UNIT);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_UNIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mileage_recorder.sv
// mileage_recorder
//   Vehicle odometer: an OFF/IDLE/DRIVE state machine, a drive-time
//   prescaler (tick_gen) and the accumulated mileage register.
//   Ports:
//     clk        : system clock, rising edge
//     rst_n      : asynchronous active-low reset
//     power_now  : 1 = vehicle powered
//     moving     : 1 = vehicle moving (ignored while unpowered)
//     clear      : synchronous mileage clear, honoured only while powered
//     record     : accumulated mileage, 0..99_999_999
//     record_upd : one-cycle pulse in the cycle record takes a new value
//     state      : current FSM state (OFF=0, IDLE=1, DRIVE=2)
//   Parameter TICKS_PER_UNIT : clk cycles of driving per mileage unit
//   Build option MILEAGE_SAT_EN : when defined, record saturates at
//     99_999_999 instead of wrapping to 0.
module mileage_recorder
  import mileage_recorder_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 power_now,
  input  logic                 moving,
  input  logic                 clear,
  output logic [MILEAGE_W-1:0] record,
  output logic                 record_upd,
  output logic [1:0]           state
);

  state_t               state_q;
  state_t               state_d;
  logic [MILEAGE_W-1:0] record_q;
  logic [MILEAGE_W-1:0] record_nxt;
  logic                 upd_q;
  logic                 clr_apply;
  logic                 tick;
  logic                 inc_apply;
  logic                 at_max;

  always_comb begin
    state_d = OFF;
    if (power_now) begin
      state_d = moving ? DRIVE : IDLE;
    end
  end

  assign clr_apply = clear && power_now;
  assign at_max    = (record_q == MILEAGE_MAX);

  // A clear pulls the prescaler enable low so the partial count is dropped
  // on the same edge as the record reset, without a dedicated clear port.
  tick_gen #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   ((state_q == DRIVE) && !clr_apply),
    .tick (tick)
  );

`ifdef MILEAGE_SAT_EN
  assign inc_apply  = tick && !at_max;
  assign record_nxt = record_q + 1'b1;
`else
  assign inc_apply  = tick;
  assign record_nxt = at_max ? '0 : record_q + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      record_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      upd_q   <= clr_apply || inc_apply;
      if (clr_apply) begin
        record_q <= '0;
      end else if (inc_apply) begin
        record_q <= record_nxt;
      end
    end
  end

  assign record     = record_q;
  assign record_upd = upd_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mileage_recorder.sv
// tb_mileage_recorder
//   Scoreboard bench for mileage_recorder with TICKS_PER_UNIT = 4.
//   The driver applies inputs on the falling edge, and after each rising
//   edge advances a reference model that tracks elapsed drive time and
//   mileage arithmetically. Expected per-cycle observations and expected
//   record values for each update pulse go into queues; the monitor pops
//   them on the following falling edge.
module tb_mileage_recorder;

  localparam int unsigned T    = 4;
  localparam int unsigned MAXV = 99_999_999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        power_now;
  logic        moving;
  logic        clear;
  logic [26:0] record;
  logic        record_upd;
  logic [1:0]  state;

  mileage_recorder #(.TICKS_PER_UNIT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .power_now (power_now),
    .moving    (moving),
    .clear     (clear),
    .record    (record),
    .record_upd(record_upd),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned st;
    int unsigned rec;
    bit          upd;
  } obs_t;

  obs_t        cyc_q[$];
  int unsigned upd_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode (0 off, 1 idle, 2 drive), cycles spent driving
  // since the last unit was credited, and the mileage total.
  int unsigned m_mode  = 0;
  int unsigned m_drive = 0;
  int unsigned m_rec   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit pn, input bit mv, input bit clr);
    bit          due;
    bit          upd;
    due = (m_mode == 2) && (m_drive + 1 == T);
    upd = 1'b0;
    if (pn && clr) begin
      m_rec   = 0;
      m_drive = 0;
      upd     = 1'b1;
    end else if (due) begin
      m_drive = 0;
`ifdef MILEAGE_SAT_EN
      if (m_rec != MAXV) begin
        m_rec = m_rec + 1;
        upd   = 1'b1;
      end
`else
      m_rec = (m_rec + 1) % (MAXV + 1);
      upd   = 1'b1;
`endif
    end else begin
      m_drive = (m_mode == 2) ? m_drive + 1 : 0;
    end
    m_mode = !pn ? 0 : (mv ? 2 : 1);
    if (upd) upd_q.push_back(m_rec);
    cyc_q.push_back('{st: m_mode, rec: m_rec, upd: upd});
  endfunction

  task automatic step(input bit pn, input bit mv, input bit clr);
    @(negedge clk);
    power_now = pn;
    moving    = mv;
    clear     = clr;
    @(posedge clk);
    model_edge(pn, mv, clr);
  endtask

  // Asynchronous reset pulse placed between two rising edges.
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_record", record, 0);
    chk("async_rst_upd", record_upd, 0);
    chk("async_rst_state", state, 0);
    m_mode  = 0;
    m_drive = 0;
    m_rec   = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_edge(power_now, moving, clear);
  endtask

  task automatic preload(input int unsigned v);
    @(negedge clk);
    #1 force dut.record_q = 27'(v);
    #1 release dut.record_q;
    m_rec = v;
    @(posedge clk);
    model_edge(power_now, moving, clear);
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("cyc_state", state, e.st);
      chk("cyc_record", record, e.rec);
      chk("cyc_upd", record_upd, e.upd);
    end
    if (record_upd === 1'b1) begin
      if (upd_q.size() == 0) begin
        chk("unexpected_upd", 1, 0);
      end else begin
        chk("upd_record", record, upd_q.pop_front());
      end
    end
  end

  initial begin
    int guard;
    rst_n     = 1'b0;
    power_now = 1'b0;
    moving    = 1'b0;
    clear     = 1'b0;
    #3;
    chk("reset_record", record, 0);
    chk("reset_upd", record_upd, 0);
    chk("reset_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous driving: units credited 4, 8, 12 cycles after DRIVE entry.
    step(1, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    step(1, 0, 0);
    chk("drive12_total", m_rec, 3);

    // Interrupted drive loses partial progress.
    step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 0, 0);
    chk("partial_discard_total", m_rec, 0);

    // Build up to 7, then power cycle with clear attempts.
    guard = 0;
    while (m_rec != 7 && guard < 200) begin
      step(1, 1, 0);
      guard++;
    end
    chk("reach_seven_timeout", guard < 200, 1);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, i[0], (i == 4));
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);

    // Clear on the same edge an increment is due.
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 1, 1);
    step(1, 0, 0);

    // Top of range: saturate or wrap depending on build.
    step(1, 0, 0);
    preload(MAXV);
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    step(1, 0, 0);

    // Reset between edges with the prescaler at its last count.
    step(1, 0, 1);
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    reset_pulse();
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 0, 0);

    // Randomized traffic, starting just below the top of range.
    preload(MAXV - 1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end

    step(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pending_updates", upd_q.size(), 0);
    chk("pending_cycles", cyc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
